// File: rtl/fir_param.sv
// Coefficient-programmable direct-form FIR: delay line, product, sum and requantise stages.
// Optional output saturation is built when FIR_SAT_EN is defined; otherwise the result wraps.
module fir_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              sat_out
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam logic signed [COEF_W-1:0] H_INIT =
    COEF_W'(((1 << (COEF_W - 1)) + TAPS / 2) / TAPS);
  localparam logic signed [ACC_W-1:0] R_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] R_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] x_p0    [TAPS];
  logic signed [COEF_W-1:0] h       [TAPS];
  logic signed [PROD_W-1:0] prod_p1 [TAPS];
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  sum_p2;
  logic                     vld_p0, vld_p1, vld_p2;
  logic [DATA_W-1:0]        q_c;
  logic                     sat_c;
  logic                     addr_ok;

  // Round half up, then arithmetic shift back to the sample's fractional scale.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] bias;
    bias = '0;
    bias[COEF_W-2] = 1'b1;
    return (s + bias) >>> (COEF_W - 1);
  endfunction

  // Returns {saturated, clamped sample}.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] r);
    if (r > R_MAX)      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (r < R_MIN) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                return {1'b0, r[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] wrap(input logic signed [ACC_W-1:0] r);
    return r[DATA_W-1:0];
  endfunction

  assign addr_ok = ({1'b0, coef_addr} < (ADDR_W+1)'(TAPS));

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < TAPS; k++) sum_c = sum_c + ACC_W'(prod_p1[k]);
  end

`ifdef FIR_SAT_EN
  logic [DATA_W:0] sq_c;
  assign sq_c  = saturate(round_shift(sum_p2));
  assign q_c   = sq_c[DATA_W-1:0];
  assign sat_c = sq_c[DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n)                sat_out <= 1'b0;
    else if (vld_p2 && !flush) sat_out <= sat_c;
  end
`else
  assign q_c     = wrap(round_shift(sum_p2));
  assign sat_c   = 1'b0;
  assign sat_out = sat_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_p0[k]    <= '0;
        h[k]       <= H_INIT;
        prod_p1[k] <= '0;
      end
      sum_p2    <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      // S0: delay line
      if (flush) begin
        x_p0[0] <= valid_in ? data_in : '0;
        for (int k = 1; k < TAPS; k++) x_p0[k] <= '0;
      end else if (valid_in) begin
        x_p0[0] <= data_in;
        for (int k = 1; k < TAPS; k++) x_p0[k] <= x_p0[k-1];
      end
      vld_p0 <= valid_in;
      // S1: products
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= PROD_W'(x_p0[k]) * PROD_W'(h[k]);
      vld_p1 <= vld_p0 & ~flush;
      // S2: full-precision sum
      sum_p2 <= sum_c;
      vld_p2 <= vld_p1 & ~flush;
      // S3: requantised output, held between valid results
      valid_out <= vld_p2 & ~flush;
      if (vld_p2 && !flush) data_out <= q_c;
      if (coef_we && addr_ok) h[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_param.sv
// Randomised and directed bench for fir_param against a sample-history reference model.
module tb_fir_param;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              flush = 1'b0;
  logic              coef_we = 1'b0;
  logic [ADDR_W-1:0] coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              sat_out;

  fir_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .valid_out(valid_out), .data_out(data_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
    logic        sat;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          edge_no = 0;
  int          hm   [TAPS];
  int          hist [TAPS];
  exp_t        pend [$];
  logic [15:0] last_data = '0;
  logic        last_sat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_no, got, exp);
    end
  endtask

  // Expected output of one sample: dot product of history and coefficients, rounded half up.
  task automatic model_out(output logic [15:0] q, output logic sat);
    longint s, r;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(hm[k]);
    r = (s + 16384) >>> 15;
    sat = 1'b0;
    q = r[15:0];
`ifdef FIR_SAT_EN
    if (r > 32767)       begin q = 16'h7FFF; sat = 1'b1; end
    else if (r < -32768) begin q = 16'h8000; sat = 1'b1; end
`endif
  endtask

  task automatic step();
    exp_t e;
    logic exp_v;
    @(posedge clk);
    edge_no++;
    if (!rst_n) begin
      pend.delete();
      for (int k = 0; k < TAPS; k++) begin hm[k] = 4096; hist[k] = 0; end
      last_data = '0;
      last_sat = 1'b0;
    end else begin
      if (coef_we && int'(coef_addr) < TAPS) hm[coef_addr] = int'($signed(coef_data));
      if (flush) begin
        pend.delete();
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
      end
      if (valid_in) begin
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(data_in));
        e.due = edge_no + 3;
        model_out(e.val, e.sat);
        pend.push_back(e);
      end
    end
    #1;
    exp_v = (pend.size() > 0) && (pend[0].due == edge_no);
    if (exp_v) begin
      e = pend.pop_front();
      last_data = e.val;
      last_sat = e.sat;
    end
    chk("valid_out", 32'(valid_out), 32'(exp_v));
    chk("data_out", 32'(data_out), 32'(last_data));
    chk("sat_out", 32'(sat_out), 32'(last_sat));
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic f,
                       input logic we, input logic [2:0] a, input logic [15:0] cd);
    valid_in = v; data_in = d; flush = f;
    coef_we = we; coef_addr = a; coef_data = cd;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic load_coefs(input logic [15:0] c);
    for (int k = 0; k < TAPS; k++) drive(1'b0, 16'h0, 1'b0, 1'b1, 3'(k), c);
  endtask

  initial begin
    // Reset held for two edges, then release idle.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    idle(3);

    // Impulse through default coefficients.
    drive(1'b1, 16'h4000, 1'b0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("impulse_first", {15'd0, valid_out, data_out}, {15'd0, 1'b1, 16'h0800});
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("impulse_tail", 32'(data_out), 32'h0000);
    idle(4);

    // Full-scale step applied on alternate cycles.
    for (int i = 0; i < 24; i++) drive(i % 2 == 0, 16'h7FFF, 1'b0, 1'b0, 3'd0, 16'h0);
    idle(4);
    chk("step_final", 32'(data_out), 32'h7FFF);

    // Coefficient rewrite while streaming a constant.
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h4000, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int k = 0; k < TAPS; k++) drive(1'b1, 16'h4000, 1'b0, 1'b1, 3'(k), 16'h2000);
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h4000, 1'b0, 1'b0, 3'd0, 16'h0);
    idle(4);

    // Saturation extremes.
    load_coefs(16'h7FFF);
    for (int i = 0; i < 12; i++) drive(1'b1, 16'h7FFF, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 12; i++) drive(1'b1, 16'h8000, 1'b0, 1'b0, 3'd0, 16'h0);
    idle(4);

    // Flush with a concurrent sample after filling the line.
    load_coefs(16'h1000);
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h4000, 1'b0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 16'h2000, 1'b1, 1'b0, 3'd0, 16'h0);
    idle(2);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("flush_result", {15'd0, valid_out, data_out}, {15'd0, 1'b1, 16'h0400});
    idle(4);

    // Randomised traffic with writes, flushes and occasional mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d, cd;
      d  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1) ? 16'h7FFF : 16'h8000)
                                       : 16'($urandom);
      cd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191));
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 29) == 0,
            $urandom_range(0, 6) == 0, 3'($urandom), cd);
    end
    rst_n = 1'b1;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
